muldiv_unit: RTL
================

# muldiv_unit

Execute-stage multi-cycle arithmetic unit for RV64M low-product multiply and all divide/remainder ops. Operands arrive from decode (srca from the register/forwarding path, srcb as selected by the extender). Results go to the execute result mux. The unit raises `busy` so the hazard unit freezes the upstream stages and inserts a bubble downstream until `done` pulses.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width.
- `CNT_W`, default 7: width of the iteration counter; must hold the value `XLEN`.

Ports (clock and reset first):
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `valid_in`, input, 1: the op in execute is an M-extension op. Sampled only in IDLE.
- `op`, input, decoded op enum (`ctl.op`): one of MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- `srca`, input, XLEN: rs1 value, already forwarded.
- `srcb`, input, XLEN: rs2 value, already forwarded.
- `flush`, input, 1: kill the in-flight op (branch mispredict or trap).
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: single-cycle pulse; `result` is valid while it is high.
- `result`, output, XLEN: final value; held until the next acceptance.

## Operation
- States:
  - IDLE: waiting for an op.
  - CALC: iterating.
  - FIN: one cycle, `done`=1.
- Accept: in IDLE, with `valid_in`=1 and `flush`=0, at the clock edge.
  - Latch the op.
  - Latch |srca| and |srcb| for signed ops; raw values for unsigned ops.
  - Latch the result sign and set counter=0.
- W variants preprocess operands at accept:
  - Signed: sign-extend bits [31:0].
  - Unsigned: zero-extend bits [31:0].
  - The final result is always sign-extended from bit 31.
- Multiply: shift-add, one multiplier bit per cycle. XLEN cycles in CALC. Result is the low XLEN bits of the product.
- Divide: restoring division, one quotient bit per cycle. XLEN cycles in CALC.
  - DIV/REM results are sign-corrected at the CALC to FIN transition.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special cases are detected at accept. These skip CALC and go straight to FIN with the result precomputed:
  - Divide by zero: quotient = all ones; remainder = dividend. For W variants the dividend is sign-extended from bit 31.
  - Signed overflow (most-negative / −1, at 64-bit or 32-bit width as applicable): quotient = dividend; remainder = 0.
- Transitions:
  - CALC → FIN when counter == XLEN−1 at the edge.
  - FIN → IDLE unconditionally.
- FIN does not accept. A new op is accepted no earlier than the cycle after FIN.
- `flush` in CALC or FIN: next state IDLE. `result` is not updated and `done` stays 0 on the following cycles.
- `flush` and `valid_in` together in IDLE: no accept.
- `valid_in` and operand changes during CALC/FIN are ignored. The hazard unit holds them stable, but the unit does not depend on that.

## Timing
- Reset values:
  - state = IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
  - Internal operand registers = 0.
- `reset` mid-operation aborts immediately (asynchronous). No `done` follows.
- `busy` and `done` are registered outputs. `result` is a registered output.
- Normal latency: accept at edge 0.
  - `busy`=1 from edge 0 through the FIN cycle.
  - `done`=1 in the cycle after edge XLEN, i.e. in the FIN state: 65 cycles for XLEN=64.
- Special-case latency: `done` in the cycle after the accept edge.
- Back-to-back: minimum 1 IDLE cycle between FIN and the next accept, so throughput is at most one op per XLEN+2 cycles.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULW compute the product combinationally at accept and go directly to FIN.
  - `done` arrives in the cycle after accept.
  - Divides are unchanged.
- Not defined: MUL/MULW use the iterative XLEN-cycle path. No `*` operator is instantiated.

## Test plan
- DIVU srca=100, srcb=7 → `done` at the cycle after edge 64, `result`=14. REMU same operands → 2. `busy` high for 65 cycles.
- DIV srca=−7, srcb=2 → −3 (0xFFFF_FFFF_FFFF_FFFD). REM → −1. DIVW srca=0x0000_0000_8000_0000, srcb=−1 → 0xFFFF_FFFF_8000_0000 in 1 cycle.
- DIV srca=5, srcb=0 → 0xFFFF_FFFF_FFFF_FFFF. REMUW srca=0x1_0000_0005, srcb=0 → 5. Both with `done` in the cycle after accept.
- MULW srca=0x7FFF_FFFF, srcb=2 → 0xFFFF_FFFF_FFFF_FFFE. MUL 0xFFFF_FFFF_FFFF_FFFF × 3 → 0xFFFF_FFFF_FFFF_FFFD. Latency is 65 cycles, or 1 cycle with `MULDIV_FAST_MUL_EN`.
- `flush` at CALC iteration 10 → next cycle IDLE, `busy`=0, no `done`, `result` keeps its previous value. Next DIVU 9/3 completes normally → 3.
- Async `reset` pulse mid-CALC, not clock-aligned → all outputs 0 immediately. `valid_in`+`flush` together in IDLE → no accept, `busy` stays 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle M-extension execute unit: low-product multiply (MUL, MULW) and
// all divide/remainder ops (DIV, DIVU, REM, REMU and their W forms).
// Multiply is shift-add, divide is restoring division; both retire one bit per
// cycle for XLEN cycles. Divide-by-zero and signed overflow are resolved at
// accept and skip the iteration entirely.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   -> MUL/MULW use a combinational product at accept and finish in
//                one cycle; divides are unchanged.
//   undefined -> MUL/MULW iterate like divides; no multiplier is built.
//
// Ports:
//   clk       single clock, rising edge
//   reset     asynchronous, active-high
//   valid_in  M-extension op present in execute (sampled only when idle)
//   op        decoded op code (see OP_* encodings below)
//   srca      rs1 value (already forwarded)
//   srcb      rs2 value (already forwarded)
//   flush     kill the in-flight op
//   busy      high whenever the unit is not idle (registered)
//   done      one-cycle pulse, result valid while high (registered)
//   result    final value, held until the next completion (registered)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // Op encodings shared with the decoder.
  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULW  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_REM   = 4'd4;
  localparam logic [3:0] OP_REMU  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_DIVUW = 4'd7;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              is_mul_reg;
  logic              is_rem_reg;
  logic              is_w_reg;
  logic              neg_reg;
  // Multiply: a_reg = shifting multiplicand, b_reg = shifting multiplier,
  //           acc_reg = partial product.
  // Divide:   q_reg = dividend shifting out / quotient shifting in,
  //           b_reg = divisor, acc_reg = partial remainder.
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]   q_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;

  // ---------------------------------------------------------------------------
  // Accept-time decode and operand preparation
  // ---------------------------------------------------------------------------
  logic            op_mul, op_w, op_sgn, op_rem;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b;
  logic            sign_a, sign_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_raw, special_res;

  always_comb begin
    op_mul = (op == OP_MUL) || (op == OP_MULW);
    op_w   = (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
             (op == OP_REMW) || (op == OP_REMUW);
    op_sgn = (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
    op_rem = (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);

    if (op_w) begin
      a_ext = op_sgn ? sext32(srca[31:0]) : {{(XLEN-32){1'b0}}, srca[31:0]};
      b_ext = op_sgn ? sext32(srcb[31:0]) : {{(XLEN-32){1'b0}}, srcb[31:0]};
    end else begin
      a_ext = srca;
      b_ext = srcb;
    end

    sign_a = op_sgn & a_ext[XLEN-1];
    sign_b = op_sgn & b_ext[XLEN-1];
    abs_a  = sign_a ? -a_ext : a_ext;
    abs_b  = sign_b ? -b_ext : b_ext;

    div_zero = op_w ? (srcb[31:0] == 32'd0) : (srcb == '0);
    div_ovf  = op_sgn & (op_w ? ((srca[31:0] == 32'h8000_0000) && (srcb[31:0] == 32'hFFFF_FFFF))
                              : ((srca == MIN_NEG) && (srcb == '1)));
    special  = !op_mul && (div_zero || div_ovf);

    // Both special cases return either the raw dividend, all ones or zero;
    // the W forms then get the usual bit-31 sign extension.
    if (div_zero) begin
      special_raw = op_rem ? srca : '1;
    end else begin
      special_raw = op_rem ? '0 : srca;
    end
    special_res = op_w ? sext32(special_raw[31:0]) : special_raw;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0] fast_prod, fast_res;
  always_comb begin
    fast_prod = srca * srcb;
    fast_res  = op_w ? sext32(fast_prod[31:0]) : fast_prod;
  end
`endif

  // ---------------------------------------------------------------------------
  // One iteration step (both datapaths), plus the final result that is
  // captured on the last CALC edge.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] div_r_next, div_q_next, mul_acc_next;
  logic [XLEN-1:0] fin_raw, fin_signed, fin_res;

  always_comb begin
    // Bring down the next dividend bit; the partial remainder can need one
    // extra bit before the trial subtraction.
    trial        = {acc_reg, q_reg[XLEN-1]};
    ge           = trial >= {1'b0, b_reg};
    div_r_next   = ge ? (trial[XLEN-1:0] - b_reg) : trial[XLEN-1:0];
    div_q_next   = {q_reg[XLEN-2:0], ge};
    mul_acc_next = acc_reg + (b_reg[0] ? a_reg : '0);

    if (is_mul_reg) begin
      fin_raw = mul_acc_next;
    end else if (is_rem_reg) begin
      fin_raw = div_r_next;
    end else begin
      fin_raw = div_q_next;
    end
    fin_signed = neg_reg ? -fin_raw : fin_raw;
    fin_res    = is_w_reg ? sext32(fin_signed[31:0]) : fin_signed;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      is_mul_reg <= 1'b0;
      is_rem_reg <= 1'b0;
      is_w_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      q_reg      <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (valid_in && !flush) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            is_mul_reg <= op_mul;
            is_rem_reg <= op_rem;
            is_w_reg   <= op_w;
            acc_reg    <= '0;
            if (op_mul) begin
              // The low product is sign-agnostic, so raw operands suffice.
              a_reg   <= srca;
              b_reg   <= srcb;
              q_reg   <= '0;
              neg_reg <= 1'b0;
            end else begin
              a_reg   <= '0;
              b_reg   <= abs_b;
              q_reg   <= abs_a;
              neg_reg <= op_rem ? sign_a : (sign_a ^ sign_b);
            end

            if (special) begin
              state_reg  <= ST_FIN;
              done_reg   <= 1'b1;
              result_reg <= special_res;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (op_mul) begin
              state_reg  <= ST_FIN;
              done_reg   <= 1'b1;
              result_reg <= fast_res;
            end
`endif
            else begin
              state_reg <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (is_mul_reg) begin
              acc_reg <= mul_acc_next;
              a_reg   <= {a_reg[XLEN-2:0], 1'b0};
              b_reg   <= {1'b0, b_reg[XLEN-1:1]};
            end else begin
              acc_reg <= div_r_next;
              q_reg   <= div_q_next;
            end
            if (cnt_reg == CNT_LAST) begin
              state_reg  <= ST_FIN;
              done_reg   <= 1'b1;
              result_reg <= fin_res;
            end
          end
        end

        ST_FIN: begin
          // Flush here lands in the same place; FIN never accepts.
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule
